pipelined_mux_tree: RTL
=======================

Name: pipelined_mux_tree

Overview:
Parametrised W-bit, N:1 select tree with per-level pipeline registers and valid/ready flow control, generalising the 1-bit 32:1 mux tree used in register-file read paths. Each level halves the candidate set using one select bit, LSB first. A side tag travels with each request. Used for wide, registered operand and forwarding selection in the pipelined CPU datapath, where backpressure from the consumer must stall the tree without losing data.

Parameters:
WIDTH, 64, bits per input word and output word
NUM_IN, 32, number of inputs; power of two, at least 2
SEL_W, $clog2(NUM_IN), select width (derived; not overridden)
TAG_W, 5, width of the passthrough tag
PIPE, 1, 1 = register after every level (latency SEL_W); 0 = combinational tree plus one output register (latency 1)

Ports:
clk  input  1  system clock; all state updates on posedge
reset_n  input  1  asynchronous, active-low reset
flush  input  1  synchronous; clears all in-flight requests
in_valid  input  1  request present
in_ready  output  1  tree accepts the request this cycle
din  input  NUM_IN*WIDTH  flattened inputs; word k is din[k*WIDTH +: WIDTH]
sel  input  SEL_W  index of the word to output
tag_in  input  TAG_W  request tag
out_valid  output  1  result present
out_ready  input  1  consumer accepts the result
dout  output  WIDTH  selected word (din word at index sel)
tag_out  output  TAG_W  tag accompanying dout

Behaviour:
- Stages: PIPE=1 gives S=SEL_W register stages. Stage j (1-based) holds NUM_IN>>j words, the unused select bits sel[SEL_W-1:j], the tag and a valid bit. Stage j's data is the 2:1 reduction of stage j-1 under sel bit j-1, with even index = d0 and odd index = d1; stage 0 is the port inputs. PIPE=0 gives S=1: the full combinational tree feeds one output register.
- Output: dout, tag_out and out_valid come from stage S's registers; there is no combinational path from din to dout.
- Flow control: ready_S = !v_S || out_ready; ready_j = !v_j || ready_{j+1}; in_ready = ready_1. Stage j loads when ready_j is high. On a load, v_j takes the upstream valid (in_valid for stage 1). Registers of a stage that is not loading hold their values.
- Combinational path: in_ready depends on out_ready through the ready chain. This is intentional; the consumer must not make out_ready depend on in_valid.
- Transfers: input transfer = in_valid && in_ready; output transfer = out_valid && out_ready. While out_valid is high and out_ready is low, dout and tag_out stay stable.
- Latency and throughput: with no stalls, a request accepted at cycle t presents at cycle t+S. Throughput is one request per cycle. A full stalled pipe holds exactly S requests.
- Ordering: requests leave in acceptance order. None are dropped or duplicated.
- Reset (reset_n low, asynchronous): all valid bits go to 0, all data, select and tag registers go to 0. Therefore out_valid=0, dout=0 and tag_out=0 immediately. in_ready=1 while reset_n is low and after release. Reset mid-operation discards every in-flight request.
- Flush (sync): at the next edge all valid bits go to 0. A request presented in the same cycle as flush is not captured, and in_ready is forced to 0 during flush. Data registers need not clear.
- Boundary cases:
  - sel=0 selects word 0; sel=NUM_IN-1 selects the top word.
  - NUM_IN=2 gives S=1 for both PIPE values.
  - Simultaneous output transfer and input transfer into a full pipe is legal and keeps the pipe full.

Test Plan:
- Reset: hold reset_n=0 mid-stream with 3 requests in flight -> out_valid=0, dout=0 and tag_out=0 asynchronously; after release, in_ready=1 and no stale output.
- Sweep (PIPE=1, NUM_IN=32, WIDTH=64): din word k = 64'hA5A5_0000_0000_0000 | k, out_ready=1, send sel=0..31 back-to-back with tag=sel -> starting 5 cycles after the first accept, one output per cycle with dout[7:0]=sel and tag_out=sel, in order.
- Backpressure: stream 8 requests, drop out_ready for 6 cycles -> in_ready falls after the pipe holds 5, dout stays stable, then all 8 drain in order with no gaps once out_ready=1.
- Flush: 4 in flight, pulse flush with in_valid=1, sel=7 -> next cycle out_valid=0; the sel=7 request never appears.
- PIPE=0 build: sel=31, din word 31 = 64'hDEAD_BEEF_0000_001F -> that value appears one cycle after accept.
- Random: 10k random sel/din/tag with random out_ready at 50% duty, checked against a queue-based reference model -> zero mismatches, order preserved, no drops or duplicates.

Source files
------------

// File: rtl/pipelined_mux_tree.sv
// W-bit N:1 select tree with per-level pipeline registers and valid/ready flow control.
// Each level halves the candidate set using one select bit, LSB first; a tag rides along.
module pipelined_mux_tree #(
    parameter int unsigned WIDTH  = 64,
    parameter int unsigned NUM_IN = 32,
    parameter int unsigned TAG_W  = 5,
    parameter int unsigned PIPE   = 1
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        flush,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [NUM_IN*WIDTH-1:0]     din,
    input  logic [$clog2(NUM_IN)-1:0]   sel,
    input  logic [TAG_W-1:0]            tag_in,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [WIDTH-1:0]            dout,
    output logic [TAG_W-1:0]            tag_out
);

    localparam int unsigned SEL_W = $clog2(NUM_IN);
    localparam int unsigned S     = (PIPE != 0) ? SEL_W : 1;
    localparam int unsigned OUT_W = TAG_W + WIDTH;

    logic [S-1:0]     r_valid;
    logic [S-1:0]     w_ready;
    logic [S:0]       w_vchain;
    logic [OUT_W-1:0] w_out_pay;

    assign w_vchain = {r_valid, in_valid};

    // A stage can load when any stage from it to the output is empty, or the consumer takes data.
    always_comb begin
        w_ready = '0;
        for (int unsigned k = 0; k < S; k++) begin
            w_ready[k] = out_ready;
            for (int unsigned m = k; m < S; m++) begin
                if (!r_valid[m]) begin
                    w_ready[k] = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_valid <= '0;
        end else if (flush) begin
            r_valid <= '0;
        end else begin
            for (int unsigned k = 0; k < S; k++) begin
                if (w_ready[k]) begin
                    r_valid[k] <= w_vchain[k];
                end
            end
        end
    end

    if (PIPE != 0) begin : g_pipe
        // Stage payload layout, MSB to LSB: tag, remaining select bits, candidate words.
        localparam int unsigned PW0 = TAG_W + SEL_W + NUM_IN * WIDTH;
        logic [PW0-1:0] w_pay0;

        assign w_pay0 = {tag_in, sel, din};

        for (genvar j = 1; j <= S; j++) begin : g_stage
            localparam int unsigned NWU = NUM_IN >> (j - 1);
            localparam int unsigned NW  = NUM_IN >> j;
            localparam int unsigned SWU = SEL_W - j + 1;
            localparam int unsigned PWU = TAG_W + SWU + NWU * WIDTH;
            localparam int unsigned PW  = TAG_W + SWU - 1 + NW * WIDTH;

            logic [PWU-1:0]      w_up;
            logic [NW*WIDTH-1:0] w_red;
            logic [PW-1:0]       w_next;
            logic [PW-1:0]       r_pay;

            if (j == 1) begin : g_src
                assign w_up = w_pay0;
            end else begin : g_src
                assign w_up = g_stage[j-1].r_pay;
            end

            always_comb begin
                w_red = '0;
                for (int unsigned k = 0; k < NW; k++) begin
                    w_red[k*WIDTH +: WIDTH] = w_up[NWU*WIDTH] ? w_up[(2*k+1)*WIDTH +: WIDTH]
                                                              : w_up[(2*k)*WIDTH +: WIDTH];
                end
            end

            if (j < S) begin : g_next
                assign w_next = {w_up[PWU-1 -: TAG_W], w_up[NWU*WIDTH+1 +: SWU-1], w_red};
            end else begin : g_next
                assign w_next = {w_up[PWU-1 -: TAG_W], w_red};
            end

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    r_pay <= '0;
                end else if (w_ready[j-1]) begin
                    r_pay <= w_next;
                end
            end
        end

        assign w_out_pay = g_stage[S].r_pay;
    end else begin : g_flat
        logic [WIDTH-1:0] w_word;
        logic [OUT_W-1:0] r_pay;

        always_comb begin
            w_word = din[WIDTH-1:0];
            for (int unsigned k = 1; k < NUM_IN; k++) begin
                if (sel == SEL_W'(k)) begin
                    w_word = din[k*WIDTH +: WIDTH];
                end
            end
        end

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                r_pay <= '0;
            end else if (w_ready[0]) begin
                r_pay <= {tag_in, w_word};
            end
        end

        assign w_out_pay = r_pay;
    end

    assign in_ready  = w_ready[0] && !flush;
    assign out_valid = w_vchain[S];
    assign dout      = w_out_pay[WIDTH-1:0];
    assign tag_out   = w_out_pay[OUT_W-1 -: TAG_W];

endmodule
